vga_pixel_scanner: RTL and testbench
====================================

# vga_pixel_scanner

Raster timing generator that produces the pixel-coordinate stream consumed by every drawing object and the sync/blanking signals for the VGA DAC. It scans 640x480@60 Hz from a 50 MHz `clk` via a pixel-tick divider, and emits `pixelX`/`pixelY` plus frame-boundary pulses for game logic. Sync and blanking outputs pass through a programmable delay line, so they stay aligned with the registered drawing/mux pipeline downstream.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `CLK_DIV`, 2: `clk` cycles per pixel, 1..4
- `SYNC_DELAY`, 2: `clk` cycles of delay on `hSync`/`vSync`/`activeVideo`, 0..7
- `SYNC_ACTIVE_LOW`, 1: 1 = syncs asserted low

Ports:
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: one clock; reset is synchronous and active-high
- `pixelX` out signed 11: current horizontal count, 0..H_TOTAL-1
- `pixelY` out signed 11: current vertical count, 0..V_TOTAL-1
- `pixelEn` out 1: one-`clk` pulse on the cycle `pixelX`/`pixelY` take a new value
- `activeVideo` out 1: delayed; high while the pixel is visible
- `hSync` out 1: delayed horizontal sync, polarity per `SYNC_ACTIVE_LOW`
- `vSync` out 1: delayed vertical sync
- `startOfFrame` out 1: one-`clk` pulse when coords become (0,0)
- `endOfFrame` out 1: one-`clk` pulse when coords become (0,V_ACTIVE), i.e. vertical blank entry

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1023; elaboration error otherwise.
- `divCnt` counts 0..CLK_DIV-1 and wraps. `tick` = (`divCnt` == CLK_DIV-1). With CLK_DIV=1, `tick` is constant 1.
- On `tick`:
  - `hCnt` increments and wraps H_TOTAL-1→0.
  - On the wrap, `vCnt` increments and wraps V_TOTAL-1→0.
- `pixelX`/`pixelY` are registered copies of `hCnt`/`vCnt`. They are raw counts, not clamped during blanking; consumers gate on `activeVideo`.
- Undelayed signals, computed from the registered counts:
  - active = (`pixelX` < H_ACTIVE) && (`pixelY` < V_ACTIVE)
  - hs = `pixelX` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = `pixelY` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], full lines
- {active, hs, vs} pass through a SYNC_DELAY-stage shift register clocked every `clk`. Polarity is applied at the output.
- All arithmetic is unsigned on 11-bit counters. The signed output type exists only for compatibility with signed object coordinates.

## Timing
- Reset values:
  - `divCnt`, `hCnt`, `vCnt`, `pixelX`, `pixelY` = 0
  - `pixelEn`, `startOfFrame`, `endOfFrame`, `activeVideo` = 0
  - `hSync`/`vSync` at their inactive level (1 when SYNC_ACTIVE_LOW)
  - all delay stages cleared to inactive
- First `tick` occurs CLK_DIV cycles after `reset` deasserts. The count then advances to (1,0). The (0,0) pixel is shown for CLK_DIV cycles immediately after reset, with no `startOfFrame` pulse.
- `pixelEn`, `startOfFrame`, `endOfFrame` are registered with the counts and high on the same cycle the new value appears.
- `activeVideo`/`hSync`/`vSync` lag the coordinate change by exactly SYNC_DELAY `clk` cycles. SYNC_DELAY=0 means combinational from the registered counts.
- Reset asserted mid-frame: on the next edge, all state returns to the reset values. No partial-line completion.
- Frame length is exactly H_TOTAL·V_TOTAL·CLK_DIV `clk` cycles (840 000 with defaults).

## Structure
- Package `vga_timing_pkg`:
  - `typedef logic signed [10:0] coord_t`
  - default 640x480 timing constants
  - derived H_TOTAL/V_TOTAL functions
- Sub-module `sync_delay_line`: parameterised width/depth shift register with synchronous reset to a parameter value. Instantiated once for {active, hs, vs}.

## Test plan
- Reset release, CLK_DIV=2: `pixelEn` first high at cycle 2 with `pixelX`=1. `pixelX` reaches 799 then 0, with `pixelY` going 0→1 on that same cycle.
- Full frame, defaults:
  - `startOfFrame` pulses every 840 000 cycles.
  - `endOfFrame` pulses exactly 480·800·2 = 768 000 cycles after `startOfFrame`.
- Sync windows:
  - `hSync` low for 96 ticks, starting SYNC_DELAY=2 cycles after `pixelX` becomes 656.
  - `vSync` low for 2·800 ticks, starting 2 cycles after (0,490).
- `activeVideo` high 640 ticks per line on lines 0..479 only. It is low on (640,0), (0,480), (799,524).
- Mid-frame `reset` at (300,200) held 1 cycle: next cycle all outputs equal the reset values and no spurious `startOfFrame` is produced.
- CLK_DIV=1, SYNC_DELAY=0, SYNC_ACTIVE_LOW=0: `pixelEn` constantly 1, `hSync` high exactly when 656 ≤ `pixelX` ≤ 751 on the same cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: coordinate type and default 640x480@60 raster timing
package vga_timing_pkg;
  typedef logic signed [10:0] coord_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: width x depth shift register, synchronous reset to RST_VAL
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_reg
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    always_comb begin
      stage_d    = stage_q << WIDTH;
      stage_d[0] = din;
    end
    always_ff @(posedge clk) begin
      if (rst) stage_q <= {DEPTH{RST_VAL}};
      else     stage_q <= stage_d;
    end
    assign dout = stage_q[DEPTH-1];
  end
endmodule

// File: rtl/vga_pixel_scanner.sv
// vga_pixel_scanner: raster counters, frame pulses and delayed sync/blank for the VGA DAC
module vga_pixel_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int CLK_DIV         = 2,
  parameter int SYNC_DELAY      = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  output coord_t pixelX,
  output coord_t pixelY,
  output logic   pixelEn,
  output logic   activeVideo,
  output logic   hSync,
  output logic   vSync,
  output logic   startOfFrame,
  output logic   endOfFrame
);
  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (HT > 1023 || VT > 1023 || CLK_DIV < 1 || CLK_DIV > 4 || SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_param
    $error("vga_pixel_scanner: timing parameters out of range");
  end
  logic [1:0]  div_q, div_d;
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        en_q, en_d, sof_q, sof_d, eof_q, eof_d;
  logic        tick, act, hs, vs;
  logic [2:0]  dly;
  always_comb begin
    tick   = div_q == 2'(CLK_DIV - 1);
    div_d  = tick ? 2'd0 : div_q + 2'd1;
    hcnt_d = !tick ? hcnt_q : hcnt_q == 11'(HT - 1) ? 11'd0 : hcnt_q + 11'd1;
    vcnt_d = !(tick && hcnt_q == 11'(HT - 1)) ? vcnt_q : vcnt_q == 11'(VT - 1) ? 11'd0 : vcnt_q + 11'd1;
    en_d   = tick;
    sof_d  = tick && hcnt_d == 11'd0 && vcnt_d == 11'd0;
    eof_d  = tick && hcnt_d == 11'd0 && vcnt_d == 11'(V_ACTIVE);
    act    = hcnt_q < 11'(H_ACTIVE) && vcnt_q < 11'(V_ACTIVE);
    hs     = hcnt_q >= 11'(H_ACTIVE + H_FP) && hcnt_q < 11'(H_ACTIVE + H_FP + H_SYNC);
    vs     = vcnt_q >= 11'(V_ACTIVE + V_FP) && vcnt_q < 11'(V_ACTIVE + V_FP + V_SYNC);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      en_q   <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      en_q   <= en_d;
      sof_q  <= sof_d;
      eof_q  <= eof_d;
    end
  end
  // Delay stages hold logical assertion; polarity is applied only at the pins
  sync_delay_line #(.WIDTH(3), .DEPTH(SYNC_DELAY), .RST_VAL(3'b000)) u_dly (
    .clk (clk),
    .rst (reset),
    .din ({act, hs, vs}),
    .dout(dly)
  );
  assign pixelX       = coord_t'(hcnt_q);
  assign pixelY       = coord_t'(vcnt_q);
  assign pixelEn      = en_q;
  assign startOfFrame = sof_q;
  assign endOfFrame   = eof_q;
  assign activeVideo  = dly[2];
  assign hSync        = dly[1] ^ SYNC_ACTIVE_LOW;
  assign vSync        = dly[0] ^ SYNC_ACTIVE_LOW;
endmodule

// File: tb/tb_vga_pixel_scanner.sv
// tb_vga_pixel_scanner: four parameter sets checked every cycle against an arithmetic raster model
module tb_vga_pixel_scanner;
  localparam int N = 4;
  localparam int HA[N] = '{640, 20, 640, 8};
  localparam int HF[N] = '{16, 3, 16, 2};
  localparam int HW[N] = '{96, 5, 96, 3};
  localparam int HB[N] = '{48, 4, 48, 2};
  localparam int VA[N] = '{480, 12, 480, 4};
  localparam int VF[N] = '{10, 2, 10, 1};
  localparam int VW[N] = '{2, 2, 2, 1};
  localparam int VB[N] = '{33, 3, 33, 2};
  localparam int CD[N] = '{2, 3, 1, 4};
  localparam int SD[N] = '{2, 3, 0, 7};
  localparam bit AL[N] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [10:0] px[N], py[N];
  logic en[N], av[N], hsy[N], vsy[N], sof[N], eof[N];
  int t = 0;
  bit started = 1'b0;
  bit lit = 1'b1;
  int total = 0;
  int passed = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < N; i++) begin : g_dut
    vga_pixel_scanner #(
      .H_ACTIVE(HA[i]), .H_FP(HF[i]), .H_SYNC(HW[i]), .H_BP(HB[i]),
      .V_ACTIVE(VA[i]), .V_FP(VF[i]), .V_SYNC(VW[i]), .V_BP(VB[i]),
      .CLK_DIV(CD[i]), .SYNC_DELAY(SD[i]), .SYNC_ACTIVE_LOW(AL[i])
    ) u_dut (
      .clk(clk), .reset(reset), .pixelX(px[i]), .pixelY(py[i]), .pixelEn(en[i]),
      .activeVideo(av[i]), .hSync(hsy[i]), .vSync(vsy[i]),
      .startOfFrame(sof[i]), .endOfFrame(eof[i])
    );
  end
  function automatic logic [27:0] model(input int i, input int tt);
    int ht, vt, p, x, y, q, xd, yd;
    bit e, a, h, v;
    ht = HA[i] + HF[i] + HW[i] + HB[i];
    vt = VA[i] + VF[i] + VW[i] + VB[i];
    p = tt / CD[i];
    x = p % ht;
    y = (p / ht) % vt;
    e = tt > 0 && tt % CD[i] == 0;
    a = 1'b0; h = 1'b0; v = 1'b0;
    if (tt >= SD[i]) begin
      q = (tt - SD[i]) / CD[i];
      xd = q % ht;
      yd = (q / ht) % vt;
      a = xd < HA[i] && yd < VA[i];
      h = xd >= HA[i] + HF[i] && xd < HA[i] + HF[i] + HW[i];
      v = yd >= VA[i] + VF[i] && yd < VA[i] + VF[i] + VW[i];
    end
    return {11'(x), 11'(y), e, e && x == 0 && y == 0, e && x == 0 && y == VA[i], a, h ^ AL[i], v ^ AL[i]};
  endfunction
  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      errors++;
      if (errors <= 50) $display("FAIL %s t=%0d got=%h expected=%h", name, t, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      t <= 0;
      started <= 1'b1;
    end else t <= t + 1;
  end
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++)
        chk($sformatf("cfg%0d_outputs", i), {px[i], py[i], en[i], sof[i], eof[i], av[i], hsy[i], vsy[i]}, model(i, t));
      if (lit) begin
        case (t)
          0:    chk("reset_state", {px[0], py[0], en[0], sof[0], eof[0], av[0], hsy[0], vsy[0]}, {22'd0, 6'b000011});
          1:    chk("hold_origin", {17'd0, px[0]}, 28'd0);
          2:    chk("first_tick", {16'd0, en[0], px[0]}, {16'd0, 1'b1, 11'd1});
          1281: chk("active_639", {27'd0, av[0]}, 28'd1);
          1282: chk("blank_640_0", {27'd0, av[0]}, 28'd0);
          1313: chk("hsync_before", {27'd0, hsy[0]}, 28'd1);
          1314: chk("hsync_start", {27'd0, hsy[0]}, 28'd0);
          1505: chk("hsync_last", {27'd0, hsy[0]}, 28'd0);
          1506: chk("hsync_end", {27'd0, hsy[0]}, 28'd1);
          1598: chk("x_799", {6'd0, py[0], px[0]}, {6'd0, 11'd0, 11'd799});
          1600: chk("line_wrap", {6'd0, py[0], px[0]}, {6'd0, 11'd1, 11'd0});
          1151: chk("small_pre_eof", {27'd0, eof[1]}, 28'd0);
          1152: chk("small_eof", {5'd0, eof[1], py[1], px[1]}, {5'd0, 1'b1, 11'd12, 11'd0});
          1824: chk("small_sof", {5'd0, sof[1], py[1], px[1]}, {5'd0, 1'b1, 11'd0, 11'd0});
          655:  chk("cd1_hs_655", {26'd0, en[2], hsy[2]}, 28'b10);
          656:  chk("cd1_hs_656", {26'd0, en[2], hsy[2]}, 28'b11);
          751:  chk("cd1_hs_751", {27'd0, hsy[2]}, 28'd1);
          752:  chk("cd1_hs_752", {27'd0, hsy[2]}, 28'd0);
          default: ;
        endcase
      end
    end
  end
  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    do_reset(2);
    repeat (2000) @(posedge clk);
    lit = 1'b0;
    repeat (12) begin
      repeat ($urandom_range(4000, 300)) @(posedge clk);
      do_reset($urandom_range(2, 1));
    end
    repeat (4000) @(posedge clk);
    @(negedge clk);
    #1 $display("%0d errors, %0d/%0d checks passed", errors, passed, total);
    $finish;
  end
endmodule
